dp_ram_slave: RTL and testbench
===============================

Name: dp_ram_slave

Overview:
- Parametrised dual-port on-chip RAM slave for the SoC bus fabric.
- Port I: read-only, word-wide instruction fetch port. Port D: read/write data port.
- Adds byte/halfword store merging via byte-lane enables, misalignment and out-of-range error responses, and configurable wait states.
- The array is inferred behaviourally, so no vendor primitive is needed. Sits behind the interconnect as the boot/main RAM for both core masters.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; power of two, ≥16.
- WAIT_STATES, 0: extra cycles (0..15) inserted between acceptance and bdone on both ports.
- INIT_FILE, "": hex image loaded with $readmemh at elaboration when non-empty.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_ss  in  1  port I slave select
- i_bstart  in  1  port I transfer start, one-cycle pulse
- i_addr  in  32  port I byte address
- i_rdata  out  32  port I read data
- i_bdone  out  1  port I completion pulse
- i_berror  out  1  port I error, valid with i_bdone
- d_ss  in  1  port D slave select
- d_bstart  in  1  port D transfer start
- d_ttype  in  ttype_t  READ or WRITE
- d_tsize  in  tsize_t  BYTE, HALFWORD or WORD
- d_addr  in  32  port D byte address
- d_wdata  in  32  store data, right-aligned: BYTE uses [7:0], HALFWORD uses [15:0]
- d_rdata  out  32  load data, zero-extended and right-aligned
- d_bdone  out  1  port D completion pulse
- d_berror  out  1  port D error, valid with d_bdone

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - While rst_n is low, all outputs are 0 and both FSMs are IDLE.
  - Memory contents are not cleared.
  - Reset asserted mid-transfer aborts it: no bdone, and any write already committed stays.
- Per-port FSM: IDLE → WAIT → DONE → IDLE.
  - In IDLE, ss && bstart accepts the transfer and captures addr, ttype, tsize and wdata.
  - It then moves to WAIT if WAIT_STATES > 0, otherwise directly to DONE.
  - WAIT counts WAIT_STATES cycles, then goes to DONE.
  - DONE asserts bdone (plus berror if applicable) for exactly one cycle, then returns to IDLE.
- Latency: bstart sampled at edge N gives bdone high in the cycle after edge N+1+WAIT_STATES.
  - Back-to-back throughput is one transfer per 2+WAIT_STATES cycles.
- bstart outside IDLE, or without ss, is ignored.
- Error checks, evaluated at acceptance:
  - WORD with addr[1:0] ≠ 0, or HALFWORD with addr[0] ≠ 0.
  - Undefined tsize.
  - addr ≥ DEPTH_WORDS*4.
  - Port I: any addr[1:0] ≠ 0 or out-of-range address.
  - On error: no array access, rdata = 0, berror = 1 with bdone.
- Writes commit on the acceptance edge with byte enables:
  - WORD writes all four lanes.
  - HALFWORD writes lanes {1,0} when addr[1]=0, lanes {3,2} when addr[1]=1.
  - BYTE writes lane addr[1:0].
  - Unselected lanes are unchanged.
  - A write returns bdone with d_rdata = 0.
- Reads: the array read is issued on the acceptance edge; the result is registered into the rdata output for DONE.
  - BYTE returns lane addr[1:0] in [7:0].
  - HALFWORD returns [15:0] from addr[1]=0, or [31:16] from addr[1]=1.
  - WORD returns the full word.
  - rdata holds its value after DONE until the next DONE.
- Same-word collision (port D write and port I read accepted on the same edge): port I returns the old data (read-before-write).
- Only bits [log2(DEPTH_WORDS)+1:2] index the array; upper bits are used only in the range check.

Decomposition:
- bus_pkg (shared):
  - ttype_t {READ, WRITE}
  - tsize_t {BYTE, HALFWORD, WORD}
  - function size_to_be(tsize, addr[1:0]) returning a 4-bit byte-enable, or an error flag
- Sub-module dp_ram_port_fsm, instantiated twice:
  - inputs: ss, bstart, err_in
  - outputs: accept, bdone, berror, plus the wait counter
- The array and lane logic stay in the top.

Test Plan:
- Word store then load: D WRITE WORD 0x100 ← 0xDEADBEEF, then READ WORD 0x100 → d_rdata 0xDEADBEEF, berror 0, bdone 2 cycles after bstart (WAIT_STATES=0).
- Byte merge and halfword load:
  - WRITE BYTE 0x101 ← 0x55 over 0xDEADBEEF → READ WORD returns 0xDEAD55EF.
  - READ HALFWORD 0x102 → 0x0000DEAD.
  - READ BYTE 0x103 → 0x000000DE.
- Errors:
  - READ WORD 0x102 → bdone with berror 1, rdata 0.
  - WRITE WORD 0x4000 (DEPTH 4096) → berror 1 and memory unchanged.
  - Port I addr 0x6 → berror 1.
- Collision: word 0x200 = 0x11111111; D writes 0x22222222 while I reads 0x200 on the same edge → I gets 0x11111111; the next I read gets 0x22222222.
- WAIT_STATES=3: bdone arrives 5 cycles after bstart. bstart pulses during WAIT are ignored: exactly one bdone and no second access.
- Reset: rst_n low while D is in WAIT → no bdone and outputs 0. After release, a read of a previously written word returns the stored data.

Source files
------------

// File: rtl/dp_ram_slave_pkg.sv
// Shared bus types and byte-lane helpers for the dual-port RAM slave.
package dp_ram_slave_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } tsize_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] be;
    logic       err;
  } lane_sel_t;

  // Byte enables for a transfer, plus misalignment / undefined-size error.
  function automatic lane_sel_t size_to_be(input tsize_t tsize, input logic [1:0] lo);
    lane_sel_t r;
    r.be  = 4'b0000;
    r.err = 1'b0;
    case (tsize)
      BYTE:     r.be = 4'b0001 << lo;
      HALFWORD: begin
        r.be  = lo[1] ? 4'b1100 : 4'b0011;
        r.err = lo[0];
      end
      WORD:     begin
        r.be  = 4'b1111;
        r.err = (lo != 2'b00);
      end
      default:  r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Replicate right-aligned store data across all lanes it may land in.
  function automatic logic [31:0] lane_replicate(input tsize_t tsize, input logic [31:0] wdata);
    logic [31:0] r;
    case (tsize)
      BYTE:     r = {4{wdata[7:0]}};
      HALFWORD: r = {2{wdata[15:0]}};
      default:  r = wdata;
    endcase
    return r;
  endfunction

  // Pick the addressed lanes from a word and right-align them, zero-extended.
  function automatic logic [31:0] lane_align(input tsize_t tsize, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [31:0] r;
    case (tsize)
      BYTE:     r = {24'b0, word[{lo, 3'b000} +: 8]};
      HALFWORD: r = {16'b0, (lo[1] ? word[31:16] : word[15:0])};
      default:  r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dp_ram_port_fsm.sv
// Per-port transfer sequencer: IDLE -> (WAIT) -> DONE -> IDLE with registered bdone/berror.
module dp_ram_port_fsm
  import dp_ram_slave_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss,
  input  logic       bstart,
  input  logic       err_in,
  output logic       accept,
  output logic       bdone,
  output logic       berror,
  output logic       done,
  output logic [3:0] wait_cnt
);

  state_t state;
  logic   err_q;

  assign accept = (state == ST_IDLE) && ss && bstart;
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      bdone    <= 1'b0;
      berror   <= 1'b0;
    end else begin
      bdone  <= 1'b0;
      berror <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err_q    <= err_in;
            wait_cnt <= '0;
            state    <= (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          bdone  <= 1'b1;
          berror <= err_q;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dp_ram_slave.sv
// Dual-port RAM slave: read-only word port I, byte/half/word read-write port D.
module dp_ram_slave
  import dp_ram_slave_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ss,
  input  logic        i_bstart,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_bdone,
  output logic        i_berror,
  input  logic        d_ss,
  input  logic        d_bstart,
  input  ttype_t      d_ttype,
  input  tsize_t      d_tsize,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_bdone,
  output logic        d_berror
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic          i_acc, i_done, i_err;
  logic          d_acc, d_done, d_err;
  logic [3:0]    i_wcnt, d_wcnt;
  logic [AW-1:0] i_idx, d_idx;
  lane_sel_t     d_sel;
  logic [31:0]   d_wlane;
  logic [31:0]   i_mem_q, d_mem_q;
  logic          i_err_q, d_err_q, d_wr_q;
  tsize_t        d_size_q;
  logic [1:0]    d_lo_q;
  logic          unused_ok;

  assign unused_ok = ^{i_wcnt, d_wcnt};

  // Upper address bits only feed the range check; the index wraps naturally.
  assign i_idx   = i_addr[AW+1:2];
  assign d_idx   = d_addr[AW+1:2];
  assign i_err   = (i_addr[1:0] != 2'b00) || ((i_addr >> (AW + 2)) != '0);
  assign d_sel   = size_to_be(d_tsize, d_addr[1:0]);
  assign d_err   = d_sel.err || ((d_addr >> (AW + 2)) != '0);
  assign d_wlane = lane_replicate(d_tsize, d_wdata);

  dp_ram_port_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm_i (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss       (i_ss),
    .bstart   (i_bstart),
    .err_in   (i_err),
    .accept   (i_acc),
    .bdone    (i_bdone),
    .berror   (i_berror),
    .done     (i_done),
    .wait_cnt (i_wcnt)
  );

  dp_ram_port_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm_d (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss       (d_ss),
    .bstart   (d_bstart),
    .err_in   (d_err),
    .accept   (d_acc),
    .bdone    (d_bdone),
    .berror   (d_berror),
    .done     (d_done),
    .wait_cnt (d_wcnt)
  );

  // Nonblocking array reads give port I the pre-write word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (d_acc && !d_err) begin
      if (d_ttype == WRITE) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (d_sel.be[b]) mem[d_idx][8*b +: 8] <= d_wlane[8*b +: 8];
        end
      end else begin
        d_mem_q <= mem[d_idx];
      end
    end
    if (i_acc && !i_err) i_mem_q <= mem[i_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      d_wr_q   <= 1'b0;
      d_size_q <= BYTE;
      d_lo_q   <= 2'b00;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      if (i_acc) i_err_q <= i_err;
      if (d_acc) begin
        d_err_q  <= d_err;
        d_wr_q   <= (d_ttype == WRITE);
        d_size_q <= d_tsize;
        d_lo_q   <= d_addr[1:0];
      end
      if (i_done) i_rdata <= i_err_q ? '0 : i_mem_q;
      if (d_done) d_rdata <= (d_err_q || d_wr_q) ? '0 : lane_align(d_size_q, d_lo_q, d_mem_q);
    end
  end

endmodule

// File: tb/tb_dp_ram_slave.sv
// Bench for dp_ram_slave: two instances (0 and 3 wait states) share stimulus; a byte-level model checks every cycle.
module tb_dp_ram_slave;
  import dp_ram_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ss = 1'b0, i_bstart = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_ss = 1'b0, d_bstart = 1'b0;
  ttype_t      d_ttype = READ;
  tsize_t      d_tsize = WORD;
  logic [31:0] d_addr = '0, d_wdata = '0;

  logic [31:0] i_rdata [2];
  logic        i_bdone [2];
  logic        i_berror[2];
  logic [31:0] d_rdata [2];
  logic        d_bdone [2];
  logic        d_berror[2];

  always #5 clk = ~clk;

  dp_ram_slave #(.DEPTH_WORDS(4096), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_ss(i_ss), .i_bstart(i_bstart), .i_addr(i_addr),
    .i_rdata(i_rdata[0]), .i_bdone(i_bdone[0]), .i_berror(i_berror[0]),
    .d_ss(d_ss), .d_bstart(d_bstart), .d_ttype(d_ttype), .d_tsize(d_tsize),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata[0]), .d_bdone(d_bdone[0]), .d_berror(d_berror[0])
  );

  dp_ram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_ss(i_ss), .i_bstart(i_bstart), .i_addr(i_addr),
    .i_rdata(i_rdata[1]), .i_bdone(i_bdone[1]), .i_berror(i_berror[1]),
    .d_ss(d_ss), .d_bstart(d_bstart), .d_ttype(d_ttype), .d_tsize(d_tsize),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata[1]), .d_bdone(d_bdone[1]), .d_berror(d_berror[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: byte-addressed memory per instance ----------------
  logic [7:0]  mb [2][16384];
  int          cyc = 0;
  int          sched [2][2];   // [dut][0=I,1=D] edge at which bdone shows
  int          freeat[2][2];   // first edge a new transfer may be accepted
  logic [31:0] pend  [2][2];
  logic [31:0] cur   [2][2];
  bit          perr  [2][2];
  bit          e_bd  [2][2];
  bit          e_be  [2][2];
  bit          m_err;
  int          m_nb;

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] dbytes(input int k);
    return (k == 0) ? 32'd16384 : 32'd1024;
  endfunction

  function automatic logic [31:0] rd_bytes(input int k, input logic [31:0] a, input int nb);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[k][a[13:0] + 14'(i)];
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        sched[k][p] = -1; freeat[k][p] = 0; cur[k][p] = '0; pend[k][p] = '0;
        perr[k][p] = 1'b0; e_bd[k][p] = 1'b0; e_be[k][p] = 1'b0;
      end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          sched[k][p] = -1; freeat[k][p] = 0; cur[k][p] = '0;
          e_bd[k][p] = 1'b0; e_be[k][p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          e_bd[k][p] = (sched[k][p] == cyc);
          e_be[k][p] = e_bd[k][p] && perr[k][p];
          if (e_bd[k][p]) cur[k][p] = pend[k][p];
        end
        if (i_ss && i_bstart && cyc >= freeat[k][0]) begin
          m_err = (i_addr[1:0] != 2'b00) || (i_addr >= dbytes(k));
          pend[k][0]   = m_err ? '0 : rd_bytes(k, i_addr, 4);
          perr[k][0]   = m_err;
          sched[k][0]  = cyc + 1 + ws(k);
          freeat[k][0] = cyc + 2 + ws(k);
        end
        if (d_ss && d_bstart && cyc >= freeat[k][1]) begin
          m_nb  = (d_tsize == BYTE) ? 1 : (d_tsize == HALFWORD) ? 2 : (d_tsize == WORD) ? 4 : 0;
          m_err = (m_nb == 0) || (d_addr >= dbytes(k));
          if (m_nb != 0 && (d_addr % m_nb) != 0) m_err = 1'b1;
          if (!m_err && d_ttype == WRITE)
            for (int i = 0; i < m_nb; i++) mb[k][d_addr[13:0] + 14'(i)] = d_wdata[8*i +: 8];
          pend[k][1]   = (m_err || d_ttype == WRITE) ? '0 : rd_bytes(k, d_addr, m_nb);
          perr[k][1]   = m_err;
          sched[k][1]  = cyc + 1 + ws(k);
          freeat[k][1] = cyc + 2 + ws(k);
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d.i_bdone", k),  i_bdone[k],  e_bd[k][0]);
        check($sformatf("dut%0d.i_berror", k), i_berror[k], e_be[k][0]);
        check($sformatf("dut%0d.i_rdata", k),  i_rdata[k],  cur[k][0]);
        check($sformatf("dut%0d.d_bdone", k),  d_bdone[k],  e_bd[k][1]);
        check($sformatf("dut%0d.d_berror", k), d_berror[k], e_be[k][1]);
        check($sformatf("dut%0d.d_rdata", k),  d_rdata[k],  cur[k][1]);
      end
    end
  end

  // ---------------- directed transfer driver ----------------
  logic [31:0] o_drd [2], o_ird [2];
  logic        o_derr[2], o_ierr[2];
  int          o_dlat[2];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic xfer(input bit dd, input ttype_t t, input tsize_t s, input logic [31:0] a,
                      input logic [31:0] w, input bit di, input logic [31:0] ia, input bit hammer);
    bit sd[2], si[2];
    tick();
    d_ss = dd; d_bstart = dd; d_ttype = t; d_tsize = s; d_addr = a; d_wdata = w;
    i_ss = di; i_bstart = di; i_addr = ia;
    for (int k = 0; k < 2; k++) begin
      sd[k] = !dd; si[k] = !di; o_dlat[k] = 0;
      o_drd[k] = 'x; o_ird[k] = 'x; o_derr[k] = 1'bx; o_ierr[k] = 1'bx;
    end
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (hammer && n <= 3) begin
        d_ss = 1'b1; d_bstart = 1'b1; d_ttype = WRITE; d_tsize = WORD;
        d_addr = 32'h300; d_wdata = 32'hBAD00000 | 32'(n);
      end else begin
        d_ss = 1'b0; d_bstart = 1'b0;
      end
      i_ss = 1'b0; i_bstart = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (!sd[k] && d_bdone[k]) begin
          sd[k] = 1'b1; o_drd[k] = d_rdata[k]; o_derr[k] = d_berror[k]; o_dlat[k] = n;
        end
        if (!si[k] && i_bdone[k]) begin
          si[k] = 1'b1; o_ird[k] = i_rdata[k]; o_ierr[k] = i_berror[k];
        end
      end
      if (sd[0] && sd[1] && si[0] && si[1]) break;
    end
    for (int k = 0; k < 2; k++) begin
      if (!sd[k] || !si[k]) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout dut%0d: bdone seen d=%0d i=%0d required d=1 i=1", k, sd[k], si[k]);
      end
    end
  endtask

  task automatic chk_d(input string nm, input logic [31:0] r0, input logic e0,
                       input logic [31:0] r1, input logic e1);
    check({nm, ".dut0.d_rdata"}, o_drd[0], r0);
    check({nm, ".dut0.d_berror"}, o_derr[0], e0);
    check({nm, ".dut1.d_rdata"}, o_drd[1], r1);
    check({nm, ".dut1.d_berror"}, o_derr[1], e1);
  endtask

  task automatic chk_i(input string nm, input logic [31:0] r, input logic e);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.dut%0d.i_rdata", nm, k), o_ird[k], r);
      check($sformatf("%s.dut%0d.i_berror", nm, k), o_ierr[k], e);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'h4000 + 32'($urandom_range(0, 32'hFFFF));
    if (sel == 1) return $urandom | 32'h8000_0000;
    return 32'($urandom_range(0, 32'h7FF));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    repeat (3) tick();
    armed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset.dut%0d.d_rdata", k), d_rdata[k], 32'h0);
      check($sformatf("reset.dut%0d.i_bdone", k), i_bdone[k], 1'b0);
    end
    rst_n = 1'b1;

    // Image words 0..511 (dut1 only holds 0..255; the rest must error there)
    for (int w = 0; w < 512; w++) xfer(1, WRITE, WORD, 32'(w * 4), 32'hC0DE0000 | 32'(w), 0, 0, 0);

    xfer(1, WRITE, WORD, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    chk_d("wr_word", 32'h0, 1'b0, 32'h0, 1'b0);
    check("lat.dut0", 32'(o_dlat[0]), 32'd2);
    check("lat.dut1", 32'(o_dlat[1]), 32'd5);
    xfer(1, READ, WORD, 32'h100, 0, 0, 0, 0);
    chk_d("rd_word", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    xfer(1, WRITE, BYTE, 32'h101, 32'hFFFFFF55, 0, 0, 0);
    xfer(1, READ, WORD, 32'h100, 0, 0, 0, 0);
    chk_d("byte_merge", 32'hDEAD55EF, 1'b0, 32'hDEAD55EF, 1'b0);
    xfer(1, READ, HALFWORD, 32'h102, 0, 0, 0, 0);
    chk_d("rd_half_hi", 32'h0000DEAD, 1'b0, 32'h0000DEAD, 1'b0);
    xfer(1, READ, HALFWORD, 32'h100, 0, 0, 0, 0);
    chk_d("rd_half_lo", 32'h000055EF, 1'b0, 32'h000055EF, 1'b0);
    xfer(1, READ, BYTE, 32'h103, 0, 0, 0, 0);
    chk_d("rd_byte", 32'h000000DE, 1'b0, 32'h000000DE, 1'b0);
    xfer(1, READ, WORD, 32'h102, 0, 0, 0, 0);
    chk_d("misalign", 32'h0, 1'b1, 32'h0, 1'b1);
    xfer(1, READ, tsize_t'(2'b11), 32'h100, 0, 0, 0, 0);
    chk_d("bad_size", 32'h0, 1'b1, 32'h0, 1'b1);
    xfer(1, WRITE, WORD, 32'h4000, 32'h12345678, 0, 0, 0);
    chk_d("oor_wr", 32'h0, 1'b1, 32'h0, 1'b1);
    xfer(1, WRITE, WORD, 32'h400, 32'h5A5A5A5A, 0, 0, 0);
    chk_d("depth_edge", 32'h0, 1'b0, 32'h0, 1'b1);
    xfer(1, READ, WORD, 32'h000, 0, 0, 0, 0);
    chk_d("no_alias", 32'hC0DE0000, 1'b0, 32'hC0DE0000, 1'b0);
    xfer(1, READ, WORD, 32'h400, 0, 0, 0, 0);
    chk_d("rd_depth_edge", 32'h5A5A5A5A, 1'b0, 32'h0, 1'b1);
    xfer(0, READ, WORD, 0, 0, 1, 32'h6, 0);
    chk_i("i_misalign", 32'h0, 1'b1);
    xfer(0, READ, WORD, 0, 0, 1, 32'h104, 0);
    chk_i("i_read", 32'hC0DE0041, 1'b0);

    xfer(1, WRITE, WORD, 32'h200, 32'h11111111, 0, 0, 0);
    xfer(1, WRITE, WORD, 32'h200, 32'h22222222, 1, 32'h200, 0);
    chk_i("collide_old", 32'h11111111, 1'b0);
    xfer(0, READ, WORD, 0, 0, 1, 32'h200, 0);
    chk_i("collide_new", 32'h22222222, 1'b0);

    // bstart held through the busy window: only dut0 is back in IDLE once
    xfer(1, READ, WORD, 32'h100, 0, 0, 0, 1);
    chk_d("hammer", 32'hDEAD55EF, 1'b0, 32'hDEAD55EF, 1'b0);
    repeat (4) tick();
    xfer(1, READ, WORD, 32'h300, 0, 0, 0, 0);
    chk_d("hammer_mem", 32'hBAD00002, 1'b0, 32'hC0DE00C0, 1'b0);

    // Reset while dut1 sits in WAIT: write already committed, no bdone
    tick();
    d_ss = 1'b1; d_bstart = 1'b1; d_ttype = WRITE; d_tsize = WORD;
    d_addr = 32'h104; d_wdata = 32'h0BADF00D;
    tick();
    d_ss = 1'b0; d_bstart = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_mid.dut%0d.d_bdone", k), d_bdone[k], 1'b0);
      check($sformatf("rst_mid.dut%0d.d_rdata", k), d_rdata[k], 32'h0);
      check($sformatf("rst_mid.dut%0d.i_rdata", k), i_rdata[k], 32'h0);
    end
    rst_n = 1'b1;
    repeat (6) tick();
    xfer(1, READ, WORD, 32'h104, 0, 0, 0, 0);
    chk_d("after_rst", 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0);
    xfer(1, READ, WORD, 32'h100, 0, 0, 0, 0);
    chk_d("after_rst_old", 32'hDEAD55EF, 1'b0, 32'hDEAD55EF, 1'b0);

    // Randomised traffic on both ports, checked by the per-cycle model
    for (int it = 0; it < 1500; it++) begin
      tick();
      d_ss     = ($urandom_range(0, 3) != 0);
      d_bstart = ($urandom_range(0, 2) == 0);
      d_ttype  = ttype_t'($urandom_range(0, 1));
      r        = $urandom_range(0, 15);
      d_tsize  = (r == 0) ? tsize_t'(2'b11) : tsize_t'(2'(r % 3));
      d_addr   = rand_addr();
      d_wdata  = $urandom;
      i_ss     = ($urandom_range(0, 3) != 0);
      i_bstart = ($urandom_range(0, 2) == 0);
      i_addr   = ($urandom_range(0, 7) == 0) ? rand_addr() : (rand_addr() & 32'hFFFF_FFFC);
    end
    d_ss = 1'b0; d_bstart = 1'b0; i_ss = 1'b0; i_bstart = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
